// File: rtl/kalman_predict_if.sv
// rtl/kalman_predict_if.sv - start/operand/result bundle for kalman_predict
interface kalman_predict_if #(
    parameter int N = 6,
    parameter int W = 32
);
    logic               start;
    logic [N*W-1:0]     x_flat;
    logic [N*N*W-1:0]   P_flat;
    logic [N*N*W-1:0]   F_flat;
    logic [N*N*W-1:0]   Q_flat;
    logic [N*W-1:0]     xhat_flat;
    logic [N*N*W-1:0]   Phat_flat;
    logic               busy;
    logic               done;

    modport master (
        output start, x_flat, P_flat, F_flat, Q_flat,
        input  xhat_flat, Phat_flat, busy, done
    );

    modport slave (
        input  start, x_flat, P_flat, F_flat, Q_flat,
        output xhat_flat, Phat_flat, busy, done
    );
endinterface

// File: rtl/kalman_predict.sv
// rtl/kalman_predict.sv - sequential single-MAC Kalman predict: xhat=F*x, Phat=F*P*F^T+Q
module kalman_predict #(
    parameter int N    = 6,
    parameter int W    = 32,
    parameter int FRAC = 12
) (
    input  logic            clk,
    input  logic            rst,
    kalman_predict_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(N - 1);
    localparam cnt_t ONE  = cnt_t'(1);
    localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL_FX, MUL_FP, MUL_FPFT, ADD_Q, DONE} state_t;

    state_t state_q, state_d;
    cnt_t   i_q, i_d, j_q, j_d, k_q, k_d;
    logic   busy_q, busy_d, done_q, done_d;

    logic [N*W-1:0]         x_q, xs_q, xhat_q;
    logic [N*N*W-1:0]       f_q, p_q, q_q, fp_q, phat_q, p_fin;
    logic signed [2*W-1:0]  acc_q, prod, acc_sum;
    logic signed [W-1:0]    op_a, op_b;
    logic [W-1:0]           mac_res, add_res;
    logic                   last_i, last_j, last_k;

    // Bit offset of matrix element (r,c) in a row-major flat vector.
    function automatic int el(input cnt_t r, input cnt_t c);
        return W * (int'(r) * N + int'(c));
    endfunction

    // Drop the fractional bits (floor) and clamp to the W-bit signed range.
    function automatic logic [W-1:0] sat_shift(input logic signed [2*W-1:0] v);
        logic signed [2*W-1:0] s;
        s = v >>> FRAC;
        if (s > MAXV) return MAXV[W-1:0];
        if (s < MINV) return MINV[W-1:0];
        return s[W-1:0];
    endfunction

    // W-bit signed add with clamping on overflow.
    function automatic logic [W-1:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) return s[W] ? MINV[W-1:0] : MAXV[W-1:0];
        return s[W-1:0];
    endfunction

    assign last_i = (i_q == LAST);
    assign last_j = (j_q == LAST);
    assign last_k = (k_q == LAST);

    // Operand selection for the shared multiplier, by phase.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            MUL_FX: begin
                op_a = f_q[el(i_q, k_q) +: W];
                op_b = x_q[W*int'(k_q) +: W];
            end
            MUL_FP: begin
                op_a = f_q[el(i_q, k_q) +: W];
                op_b = p_q[el(k_q, j_q) +: W];
            end
            MUL_FPFT: begin
                op_a = fp_q[el(i_q, k_q) +: W];
                op_b = f_q[el(j_q, k_q) +: W];
            end
            default: ;
        endcase
    end

    assign prod    = op_a * op_b;
    assign acc_sum = (k_q == '0) ? prod : acc_q + prod;
    assign mac_res = sat_shift(acc_sum);
    assign add_res = add_sat(p_q[el(i_q, j_q) +: W], q_q[el(i_q, j_q) +: W]);

    // Covariance image including the element finished this cycle, for the final publish.
    always_comb begin
        p_fin = p_q;
        p_fin[el(i_q, j_q) +: W] = add_res;
    end

    // Next-state, loop counters and status flags.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = MUL_FX;
                    busy_d  = 1'b1;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            MUL_FX: begin
                k_d = last_k ? '0 : k_q + ONE;
                if (last_k) begin
                    i_d = last_i ? '0 : i_q + ONE;
                    if (last_i) state_d = MUL_FP;
                end
            end
            MUL_FP, MUL_FPFT: begin
                k_d = last_k ? '0 : k_q + ONE;
                if (last_k) j_d = last_j ? '0 : j_q + ONE;
                if (last_k && last_j) i_d = last_i ? '0 : i_q + ONE;
                if (last_k && last_j && last_i)
                    state_d = (state_q == MUL_FP) ? MUL_FPFT : ADD_Q;
            end
            ADD_Q: begin
                j_d = last_j ? '0 : j_q + ONE;
                if (last_j) i_d = last_i ? '0 : i_q + ONE;
                if (last_j && last_i) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand capture, accumulation, scratch write-back and result publish.
    // P storage is reused for S and then Phat once F*P has consumed it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            f_q    <= '0;
            p_q    <= '0;
            q_q    <= '0;
            fp_q   <= '0;
            xs_q   <= '0;
            acc_q  <= '0;
            xhat_q <= '0;
            phat_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_q <= '0;
                    if (bus.start) begin
                        x_q <= bus.x_flat;
                        f_q <= bus.F_flat;
                        p_q <= bus.P_flat;
                        q_q <= bus.Q_flat;
                    end
                end
                MUL_FX: begin
                    acc_q <= acc_sum;
                    if (last_k) xs_q[W*int'(i_q) +: W] <= mac_res;
                end
                MUL_FP: begin
                    acc_q <= acc_sum;
                    if (last_k) fp_q[el(i_q, j_q) +: W] <= mac_res;
                end
                MUL_FPFT: begin
                    acc_q <= acc_sum;
                    if (last_k) p_q[el(i_q, j_q) +: W] <= mac_res;
                end
                ADD_Q: begin
                    p_q[el(i_q, j_q) +: W] <= add_res;
                    if (last_i && last_j) begin
                        xhat_q <= xs_q;
                        phat_q <= p_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.xhat_flat = xhat_q;
    assign bus.Phat_flat = phat_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_kalman_predict.sv
// tb/tb_kalman_predict.sv - directed vector bench for kalman_predict
module tb_kalman_predict;
    localparam int N = 6;
    localparam int W = 32;

    typedef logic [N*W-1:0]   vec_t;
    typedef logic [N*N*W-1:0] mat_t;
    typedef struct {
        string name;
        vec_t  x;
        mat_t  p;
        mat_t  f;
        mat_t  q;
        vec_t  xh;
        mat_t  ph;
    } tv_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    tv_t  tbl[5];

    kalman_predict_if #(.N(N), .W(W)) bus();

    kalman_predict #(.N(N), .W(W), .FRAC(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic mat_t diag(input logic [31:0] v);
        mat_t m = '0;
        for (int i = 0; i < N; i++) m[W*(i*N+i) +: W] = v;
        return m;
    endfunction

    function automatic mat_t setel(input mat_t m, input int r, input int c, input logic [31:0] v);
        m[W*(r*N+c) +: W] = v;
        return m;
    endfunction

    function automatic vec_t setv(input vec_t x, input int i, input logic [31:0] v);
        x[W*i +: W] = v;
        return x;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int e = 0; e < N*N; e++) m[W*e +: W] = $urandom;
        return m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_m(input string nm, input mat_t act, input mat_t exp, input int cnt);
        int bad = -1;
        for (int e = cnt - 1; e >= 0; e--)
            if (act[W*e +: W] !== exp[W*e +: W]) bad = e;
        n_vec++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL %s: element %0d got %08h expected %08h",
                     nm, bad, act[W*bad +: W], exp[W*bad +: W]);
        end
    endtask

    task automatic load_and_start(input int vi);
        @(negedge clk);
        bus.x_flat = tbl[vi].x;
        bus.P_flat = tbl[vi].p;
        bus.F_flat = tbl[vi].f;
        bus.Q_flat = tbl[vi].q;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.x_flat = vec_t'(rand_mat());
        bus.P_flat = rand_mat();
        bus.F_flat = rand_mat();
        bus.Q_flat = rand_mat();
    endtask

    task automatic run_vec(input int vi, input bit pulses, input bit hold);
        int done_edge = -1;
        bit busy_bad  = 1'b0;
        bit stuck_bad = 1'b0;
        load_and_start(vi);
        for (int e = 1; e <= 600 && done_edge < 0; e++) begin
            if (pulses && (e == 10 || e == 200)) bus.start = 1'b1;
            if (hold && e == 500) bus.start = 1'b1;
            @(posedge clk);
            #1;
            if (pulses && (e == 10 || e == 200)) bus.start = 1'b0;
            if (bus.done) done_edge = e;
            else if (!bus.busy) busy_bad = 1'b1;
        end
        chk({tbl[vi].name, ".done_edge"}, done_edge, 504);
        chk({tbl[vi].name, ".busy_gap"}, int'(busy_bad), 0);
        chk({tbl[vi].name, ".busy_at_done"}, int'(bus.busy), 0);
        chk_m({tbl[vi].name, ".xhat"}, mat_t'(bus.xhat_flat), mat_t'(tbl[vi].xh), N);
        chk_m({tbl[vi].name, ".Phat"}, bus.Phat_flat, tbl[vi].ph, N*N);
        if (hold) begin
            for (int e = 0; e < 5; e++) begin
                @(posedge clk);
                #1;
                if (!bus.done || bus.busy) stuck_bad = 1'b1;
            end
            chk({tbl[vi].name, ".done_held"}, int'(stuck_bad), 0);
            bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tbl[vi].name, ".done_clear"}, int'(bus.done), 0);
        chk_m({tbl[vi].name, ".xhat_hold"}, mat_t'(bus.xhat_flat), mat_t'(tbl[vi].xh), N);
    endtask

    initial begin
        vec_t v;
        mat_t m;

        // Identity
        v = '0;
        for (int i = 0; i < N; i++) v = setv(v, i, 32'((i + 1) * 32'h1000));
        tbl[0] = '{"ident", v, diag(32'h1000), diag(32'h1000), '0, v, diag(32'h1000)};

        // Constant velocity
        m = diag(32'h1000);
        m = setel(m, 0, 3, 32'h1000);
        m = setel(m, 1, 4, 32'h1000);
        m = setel(m, 2, 5, 32'h1000);
        tbl[1].name = "cv";
        tbl[1].f = m;
        tbl[1].p = diag(32'h1000);
        tbl[1].q = diag(32'h29);
        v = '0;
        v = setv(v, 0, 32'h1000); v = setv(v, 1, 32'h2000); v = setv(v, 2, 32'h3000);
        v = setv(v, 3, 32'h0800); v = setv(v, 4, 32'h0800); v = setv(v, 5, 32'h0800);
        tbl[1].x = v;
        v = setv(v, 0, 32'h1800); v = setv(v, 1, 32'h2800); v = setv(v, 2, 32'h3800);
        tbl[1].xh = v;
        m = '0;
        for (int i = 0; i < 3; i++) begin
            m = setel(m, i, i, 32'h2029);
            m = setel(m, i + 3, i + 3, 32'h1029);
            m = setel(m, i, i + 3, 32'h1000);
            m = setel(m, i + 3, i, 32'h1000);
        end
        tbl[1].ph = m;

        // Floor toward -inf: -0.5 * 1 LSB
        tbl[2].name = "floor";
        tbl[2].f = diag(32'hFFFFF800);
        tbl[2].p = diag(32'h1000);
        tbl[2].q = '0;
        tbl[2].x = setv('0, 0, 32'h00000001);
        tbl[2].xh = setv('0, 0, 32'hFFFFFFFF);
        tbl[2].ph = diag(32'h00000400);

        // MAC saturation both directions
        tbl[3].name = "sat";
        tbl[3].f = diag(32'h7FFFFFFF);
        tbl[3].p = diag(32'h1000);
        tbl[3].q = '0;
        v = setv('0, 0, 32'h7FFFFFFF);
        v = setv(v, 1, 32'h80000000);
        tbl[3].x = v;
        tbl[3].xh = v;
        tbl[3].ph = diag(32'h7FFFFFFF);

        // Q addition saturation, negative pass-through
        tbl[4].name = "qsat";
        tbl[4].f = diag(32'h1000);
        tbl[4].p = diag(32'h1000);
        m = diag(32'h7FFFFFFF);
        m = setel(m, 0, 1, 32'h80000000);
        m = setel(m, 2, 3, 32'h12345678);
        tbl[4].q = m;
        tbl[4].ph = m;
        v = '0;
        v = setv(v, 0, 32'hFFFFF000); v = setv(v, 1, 32'hFFFFFFFF); v = setv(v, 2, 32'h7FFFFFFF);
        v = setv(v, 3, 32'h80000000); v = setv(v, 4, 32'h00000800);
        tbl[4].x = v;
        tbl[4].xh = v;

        bus.start  = 1'b0;
        bus.x_flat = '0;
        bus.P_flat = '0;
        bus.F_flat = '0;
        bus.Q_flat = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        chk_m("rst.xhat", mat_t'(bus.xhat_flat), '0, N);
        chk_m("rst.Phat", bus.Phat_flat, '0, N*N);
        @(negedge clk);
        rst = 1'b1;

        for (int vi = 0; vi < 5; vi++) run_vec(vi, 1'b0, 1'b0);

        // Abort at edge 300: previous result visible until reset, then all zero
        load_and_start(1);
        repeat (299) @(posedge clk);
        #1;
        chk("abort.busy299", int'(bus.busy), 1);
        chk_m("abort.xhat299", mat_t'(bus.xhat_flat), mat_t'(tbl[4].xh), N);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort.busy", int'(bus.busy), 0);
        chk("abort.done", int'(bus.done), 0);
        chk_m("abort.xhat", mat_t'(bus.xhat_flat), '0, N);
        chk_m("abort.Phat", bus.Phat_flat, '0, N*N);
        @(negedge clk);
        rst = 1'b1;
        run_vec(1, 1'b0, 1'b0);

        // Ignored start pulses while busy, start held through DONE
        run_vec(3, 1'b1, 1'b1);
        run_vec(0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
